// File: rtl/tern_weight_loader_pkg.sv
// Shared definitions for the ternary weight loader: FSM states, 2-bit code
// values and the byte-count / counter-width derivations.
package tern_weight_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;
  localparam logic [1:0] TERN_RSVD = 2'b10;

  localparam int CODES_PER_BYTE = 4;

  function automatic int calc_nbytes(input int in_len, input int out_len);
    return (in_len * out_len) / CODES_PER_BYTE;
  endfunction

  // A single-byte load still needs a 1-bit counter to be a legal vector.
  function automatic int calc_cnt_w(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/tern_code_check.sv
// Sanitizes one 2-bit ternary code: the reserved value is forced to zero
// and flagged so the loader can raise its sticky error.
module tern_code_check
  import tern_weight_loader_pkg::*;
(
  input  logic [1:0] code_i,
  output logic [1:0] code_o,
  output logic       err_o
);

  assign err_o  = (code_i == TERN_RSVD);
  assign code_o = err_o ? TERN_ZERO : code_i;

endmodule

// File: rtl/tern_weight_loader.sv
// Streams packed ternary weights into a shadow buffer and commits them to
// the W output in one cycle, so a consumer never sees a half-loaded matrix.
module tern_weight_loader
  import tern_weight_loader_pkg::*;
#(
  parameter int InLen  = 16,
  parameter int OutLen = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_start,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  output logic [2*InLen*OutLen-1:0]  W,
  output logic                       w_valid,
  output logic                       busy,
  output logic                       commit,
  output logic                       code_err
);

  localparam int NBYTES = calc_nbytes(InLen, OutLen);
  localparam int CW     = calc_cnt_w(NBYTES);
  localparam int WW     = 2 * InLen * OutLen;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [WW-1:0]   shadow_q;
  logic [WW-1:0]   w_q;
  logic            w_valid_q;
  logic            commit_q;
  logic            code_err_q;
  logic            busy_q;
  logic            ready_q;

  logic [7:0]      byte_clean;
  logic [3:0]      lane_err;

  for (genvar gi = 0; gi < CODES_PER_BYTE; gi++) begin : g_lane
    tern_code_check u_code_check (
      .code_i (byte_in[2*gi +: 2]),
      .code_o (byte_clean[2*gi +: 2]),
      .err_o  (lane_err[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shadow_q   <= '0;
      w_q        <= '0;
      w_valid_q  <= 1'b0;
      commit_q   <= 1'b0;
      code_err_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            ready_q    <= 1'b1;
            cnt_q      <= '0;
            shadow_q   <= '0;
            code_err_q <= 1'b0;
          end
        end
        LOAD: begin
          // A restart wins over a byte offered in the same cycle.
          if (load_start) begin
            cnt_q      <= '0;
            shadow_q   <= '0;
            code_err_q <= 1'b0;
          end else if (byte_valid) begin
            shadow_q[{cnt_q, 3'b000} +: 8] <= byte_clean;
            if (|lane_err) code_err_q <= 1'b1;
            if (cnt_q == LAST_BYTE) begin
              state_q  <= COMMIT;
              ready_q  <= 1'b0;
              commit_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          w_q       <= shadow_q;
          w_valid_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = ready_q;
  assign W          = w_q;
  assign w_valid    = w_valid_q;
  assign busy       = busy_q;
  assign commit     = commit_q;
  assign code_err   = code_err_q;

endmodule

// File: doc/tern_weight_loader.md
TERN_WEIGHT_LOADER -- requirements
Module: tern_weight_loader

Interface
REQ-001 SHALL have parameter InLen, default 16, meaning matrix rows (multiplier input vector length).
REQ-002 SHALL have parameter OutLen, default 8, meaning matrix columns (multiplier output vector length).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port load_start  input  1  one-cycle pulse starting (or restarting) a weight load.
REQ-006 SHALL have port byte_in  input  8  four packed 2-bit ternary codes; bits [1:0] carry the first code.
REQ-007 SHALL have port byte_valid  input  1  byte_in valid this cycle.
REQ-008 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port W  output  2*InLen*OutLen  committed weights; code k at W[2k+:2], k = row*OutLen + col.
REQ-010 SHALL have port w_valid  output  1  W holds at least one completed load.
REQ-011 SHALL have port busy  output  1  a load is in progress.
REQ-012 SHALL have port commit  output  1  one-cycle pulse in the cycle W is updated.
REQ-013 SHALL have port code_err  output  1  sticky flag: reserved code 2'b10 received during the current or last load.

Function
REQ-014 SHALL implement states IDLE, LOAD, COMMIT.
REQ-015 IDLE -> LOAD on load_start; LOAD -> COMMIT on acceptance of byte number NBYTES-1, NBYTES = InLen*OutLen/4; COMMIT -> IDLE unconditionally after one cycle.
REQ-016 A byte SHALL be accepted exactly when byte_valid && byte_ready; byte_ready SHALL be 1 only in LOAD.
REQ-017 Accepted byte number b SHALL write shadow codes 4b..4b+3, byte_in[1:0] to code 4b.
REQ-018 Code encoding SHALL be 2'b01 = +1, 2'b11 = -1, 2'b00 = 0; 2'b10 SHALL be stored as 2'b00 and set code_err.
REQ-019 The byte counter SHALL be ceil(log2(NBYTES)) bits, cleared on load_start, and SHALL NOT wrap within a load.
REQ-020 W SHALL be double-buffered: filled into a shadow register, W copied from shadow only in COMMIT; W SHALL remain stable at all other times.
REQ-021 Latency: last byte accepted in cycle N -> state COMMIT and commit=1 in cycle N+1 -> new W visible from cycle N+2.
REQ-022 w_valid SHALL set at the first commit and clear only on reset.
REQ-023 busy SHALL be 1 in LOAD and COMMIT, 0 in IDLE.
REQ-024 load_start in LOAD SHALL restart: counter to 0, code_err cleared, previously accepted shadow bytes discarded, W unchanged; a byte presented in that cycle SHALL NOT be accepted.
REQ-025 load_start in COMMIT SHALL be ignored; the commit completes.
REQ-026 code_err SHALL clear on load_start accepted from IDLE or LOAD and otherwise hold.
REQ-027 byte_valid outside LOAD SHALL be ignored with no state change.

Reset
REQ-028 On rst_n low, asynchronously: state IDLE, counter 0, shadow 0, W 0, w_valid 0, busy 0, commit 0, code_err 0, byte_ready 0.
REQ-029 Reset mid-load SHALL discard the load; W returns to 0, not to the prior committed value.

Structure
REQ-030 A shared package SHALL hold the state enum, the ternary code constants (TERN_ZERO, TERN_POS, TERN_NEG, TERN_RSVD), and the NBYTES derivation.
REQ-031 One sub-module, tern_code_check (2-bit code in -> sanitized code out + error bit), SHALL be instantiated four times per byte lane.
REQ-032 W width and code-index ordering SHALL match the ternary multiplier W port exactly so W connects directly.

Verification
REQ-033 Full load: load_start, 32 bytes of 8'h55 with byte_valid held high -> commit in the cycle after byte 31, W = all 2'b01, w_valid=1, code_err=0.
REQ-034 Backpressure: same load with byte_valid toggled every other cycle -> identical W, commit one cycle after the 32nd accepted byte.
REQ-035 Reserved code: byte 0 = 8'b10_11_01_10 -> codes 0..3 = 00,01,11,00; code_err=1 until next load_start.
REQ-036 Restart: load_start after 10 bytes of 8'hFF, then 32 bytes of 8'h00 -> W all 0, no commit between the two load_starts.
REQ-037 Stability: commit pattern A, start load of pattern B, assert rst_n low after 20 bytes -> W = A for those 20 byte cycles, then W = 0 and w_valid=0 immediately on reset.
REQ-038 Ignore: byte_valid=1 in IDLE with 8'hFF for 5 cycles -> byte_ready=0, W and counter unchanged.
